// File: rtl/serial_rx8_pkg.sv
// Shared definitions for the serial receiver: state encoding, default width, counter sizing.
// No logic; constants and a sizing helper only.
// Not applicable: no flow control lives here.
package serial_rx8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DATA_W);

endpackage

// File: rtl/serial_rx8_rx_out_buffer.sv
// One-entry valid/ready holding register for assembled words, with overrun pulse.
// Latency: load visible one cycle after the loading falling edge.
// Backpressure: a full, unconsumed entry drops the new word and pulses overrun.
module rx_out_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_vld,
  input  logic [DATA_W-1:0] load_dat,
  input  logic              out_ready,
  output logic [DATA_W-1:0] par_out,
  output logic              out_valid,
  output logic              overrun
);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      par_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_vld) begin
        // A consume on the same edge frees the slot for the incoming word.
        if (!out_valid || out_ready) begin
          par_out   <= load_dat;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_rx8.sv
// Serial-to-parallel receiver: framed bit stream in, DATA_W-bit word out via one-entry buffer.
// Latency: word visible the cycle after the falling edge that samples its last bit.
// Backpressure: none on the serial side; a full buffer drops the new word and pulses overrun.
module serial_rx8
  import serial_rx8_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  input  logic              sframe,
  input  logic              out_ready,
  output logic [DATA_W-1:0] par_out,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  shifted_fresh;
  logic               last_bit;
  logic               load_vld;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
    if (LSB_FIRST) return {b, cur[DATA_W-1:1]};
    else           return {cur[DATA_W-2:0], b};
  endfunction

  assign shifted       = shift_in(shreg, sin);
  assign shifted_fresh = shift_in('0, sin);
  assign last_bit      = (cnt == CNT_W'(DATA_W - 1));
  assign load_vld      = (state == SHIFT) && last_bit;
  assign busy          = (state == SHIFT);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sframe) begin
            shreg <= shifted_fresh;
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The completing bit belongs to the old frame even if sframe is high.
          if (last_bit) begin
            shreg <= shifted;
            cnt   <= '0;
            state <= IDLE;
          end else if (sframe) begin
            frame_err <= 1'b1;
            shreg     <= shifted_fresh;
            cnt       <= CNT_W'(1);
          end else begin
            shreg <= shifted;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_out_buffer #(
    .DATA_W (DATA_W)
  ) u_out_buffer (
    .clk       (clk),
    .reset     (reset),
    .load_vld  (load_vld),
    .load_dat  (shifted),
    .out_ready (out_ready),
    .par_out   (par_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_rx8.sv
// Directed bench for serial_rx8: LSB-first and MSB-first instances share stimulus.
module tb_serial_rx8;

  logic       clk;
  logic       reset;
  logic       sin;
  logic       sframe;
  logic       out_ready;
  logic [7:0] par_out0, par_out1;
  logic       out_valid0, out_valid1;
  logic       busy0, busy1;
  logic       frame_err0, frame_err1;
  logic       overrun0, overrun1;

  int n_cmp = 0;
  int n_err = 0;

  serial_rx8 #(.DATA_W(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .sin(sin), .sframe(sframe), .out_ready(out_ready),
    .par_out(par_out0), .out_valid(out_valid0), .busy(busy0),
    .frame_err(frame_err0), .overrun(overrun0)
  );

  serial_rx8 #(.DATA_W(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .sin(sin), .sframe(sframe), .out_ready(out_ready),
    .par_out(par_out1), .out_valid(out_valid1), .busy(busy1),
    .frame_err(frame_err1), .overrun(overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the falling edge sample it, then settle.
  task automatic tick(input logic sf, input logic b, input logic rdy);
    sframe    = sf;
    sin       = b;
    out_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] word, input logic rdy, input logic last_rdy);
    for (int i = 0; i < 8; i++)
      tick(i == 0, word[i], (i == 7) ? last_rdy : rdy);
  endtask

  initial begin
    reset = 1'b0; sin = 1'b0; sframe = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_par_out",   par_out0,   8'h00);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_busy",      busy0,      1'b0);
    chk("rst_frame_err", frame_err0, 1'b0);
    chk("rst_overrun",   overrun0,   1'b0);
    chk("rst_par_out_m", par_out1,   8'h00);
    reset = 1'b1;

    // 0xA5 with consumer always ready
    tick(1'b1, 1'b1, 1'b1);
    chk("a5_busy_first", busy0, 1'b1);
    for (int i = 1; i < 8; i++) tick(1'b0, 1'(8'hA5 >> i), 1'b1);
    chk("a5_par_out",   par_out0,   8'hA5);
    chk("a5_out_valid", out_valid0, 1'b1);
    chk("a5_busy_done", busy0,      1'b0);
    chk("a5_par_out_m", par_out1,   8'hA5);
    tick(1'b0, 1'b0, 1'b1);
    chk("a5_valid_drop", out_valid0, 1'b0);
    chk("a5_par_keep",   par_out0,   8'hA5);

    // 0x01 bit sequence: MSB-first instance places the first bit at the top
    send_frame(8'h01, 1'b1, 1'b1);
    chk("x01_par_out_m", par_out1, 8'h80);
    chk("x01_par_out",   par_out0, 8'h01);
    tick(1'b0, 1'b0, 1'b1);

    // Back-to-back with stalled consumer
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("3c_par_out",   par_out0,   8'h3C);
    chk("3c_out_valid", out_valid0, 1'b1);
    chk("3c_overrun",   overrun0,   1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    chk("c3_overrun",   overrun0,   1'b1);
    chk("c3_par_keep",  par_out0,   8'h3C);
    chk("c3_out_valid", out_valid0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("c3_overrun_end", overrun0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("drain_valid", out_valid0, 1'b0);

    // Restart at bit 4, new frame is 0x5A
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
    chk("ferr_quiet", frame_err0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("ferr_pulse", frame_err0, 1'b1);
    chk("ferr_busy",  busy0,      1'b1);
    tick(1'b0, 1'b1, 1'b0);
    chk("ferr_end",   frame_err0, 1'b0);
    for (int i = 2; i < 7; i++) tick(1'b0, 1'(8'h5A >> i), 1'b0);
    chk("ferr_no_word", out_valid0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("5a_par_out",   par_out0,   8'h5A);
    chk("5a_out_valid", out_valid0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Load and consume on the same edge
    send_frame(8'h11, 1'b0, 1'b0);
    chk("11_par_out", par_out0, 8'h11);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("22_par_out",   par_out0,   8'h22);
    chk("22_out_valid", out_valid0, 1'b1);
    chk("22_overrun",   overrun0,   1'b0);
    tick(1'b0, 1'b0, 1'b1);

    // sframe on the completing bit is not a restart
    for (int i = 0; i < 8; i++) tick((i == 0) || (i == 7), 1'(8'h96 >> i), 1'b1);
    chk("last_sf_par",  par_out0,   8'h96);
    chk("last_sf_ferr", frame_err0, 1'b0);
    chk("last_sf_busy", busy0,      1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("last_sf_idle", busy0, 1'b0);

    // Reset mid-frame with a word still buffered
    for (int i = 0; i < 5; i++) tick(i == 0, 1'b1, 1'b0);
    chk("pre_rst_busy", busy0, 1'b1);
    sframe = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_par",   par_out0,   8'h00);
    chk("mid_rst_valid", out_valid0, 1'b0);
    chk("mid_rst_busy",  busy0,      1'b0);
    chk("mid_rst_ferr",  frame_err0, 1'b0);
    chk("mid_rst_ovr",   overrun0,   1'b0);
    @(negedge clk); #1;
    chk("mid_rst_hold", out_valid0, 1'b0);
    reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    chk("ff_ferr_first", frame_err0, 1'b0);
    for (int i = 1; i < 8; i++) tick(1'b0, 1'b1, 1'b1);
    chk("ff_par_out",   par_out0,   8'hFF);
    chk("ff_out_valid", out_valid0, 1'b1);
    chk("ff_ferr",      frame_err0, 1'b0);
    chk("ff_overrun",   overrun0,   1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
